// File: rtl/iob_vexriscv_arb_pkg.sv
// Shared definitions for the VexRiscv IOb bus arbiter: bus word widths,
// field offsets inside the packed request/response words, FSM encodings.
package iob_vexriscv_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_XFER   = 2'd1;
    localparam logic [1:0] ST_RDWAIT = 2'd2;

    // Response word is {rdata, rvalid, ready}
    localparam int RESP_READY_OFF  = 0;
    localparam int RESP_RVALID_OFF = 1;
    localparam int RESP_RDATA_OFF  = 2;

    // Request word is {valid, addr, wdata, wstrb}
    localparam int REQ_WSTRB_OFF = 0;

    function automatic int req_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic int resp_w(input int data_w);
        return data_w + 2;
    endfunction

    function automatic int req_wdata_off(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int req_addr_off(input int data_w);
        return data_w + data_w / 8;
    endfunction

    function automatic int req_valid_off(input int addr_w, input int data_w);
        return addr_w + data_w + data_w / 8;
    endfunction

endpackage

// File: rtl/iob_vexriscv_rr_sel.sv
// Next-grant picker. Round-robin after last_grant by default; defining
// IOB_VEXRISCV_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module iob_vexriscv_rr_sel
    import iob_vexriscv_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] sel
);

`ifdef IOB_VEXRISCV_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        sel = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
    end
`else
    // Distance k from last_grant: walking k downwards lets the nearest requester win.
    always_comb begin
        sel = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && (last_grant == IDX_W'((i - k + N_REQ) % N_REQ))) begin
                    sel    = '0;
                    sel[i] = 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/iob_vexriscv_bus_arb.sv
// Shares one IOb memory port between N_REQ requesters, one outstanding
// transaction at a time. Arbitration mode: IOB_VEXRISCV_ARB_FIXED_PRIO_EN.
module iob_vexriscv_bus_arb
    import iob_vexriscv_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_REQ*req_w(ADDR_W, DATA_W)-1:0] s_req,
    output logic [N_REQ*resp_w(DATA_W)-1:0]        s_resp,
    output logic [req_w(ADDR_W, DATA_W)-1:0]       m_req,
    input  logic [resp_w(DATA_W)-1:0]              m_resp,
    output logic [N_REQ-1:0]                       grant,
    output logic                                   busy
);

    localparam int REQ_W     = req_w(ADDR_W, DATA_W);
    localparam int RESP_W    = resp_w(DATA_W);
    localparam int STRB_W    = DATA_W / 8;
    localparam int OFF_VALID = req_valid_off(ADDR_W, DATA_W);
    localparam int IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [N_REQ-1:0] req_vld;
    logic [N_REQ-1:0] sel;
    logic [REQ_W-1:0] gnt_req;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_is_write;
    logic             m_ready;
    logic             m_rvalid;
    logic [DATA_W-1:0] m_rdata;

    assign m_ready  = m_resp[RESP_READY_OFF];
    assign m_rvalid = m_resp[RESP_RVALID_OFF];
    assign m_rdata  = m_resp[RESP_RDATA_OFF +: DATA_W];

    always_comb begin
        req_vld = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_vld[i] = s_req[i*REQ_W + OFF_VALID];
        end
    end

    iob_vexriscv_rr_sel #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) u_sel (
        .req       (req_vld),
        .last_grant(last_q),
        .sel       (sel)
    );

    // Granted request; all-zero when nobody owns the bus
    always_comb begin
        gnt_req = '0;
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                gnt_req = s_req[i*REQ_W +: REQ_W];
                gnt_idx = IDX_W'(i);
            end
        end
    end

    assign gnt_is_write = |gnt_req[REQ_WSTRB_OFF +: STRB_W];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (|req_vld) begin
                    grant_d = sel;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                // A dropped valid is ignored here: the owner keeps the bus until ready.
                if (m_ready) begin
                    if (gnt_is_write) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        last_d  = gnt_idx;
                    end else begin
                        state_d = ST_RDWAIT;
                    end
                end
            end
            ST_RDWAIT: begin
                if (m_rvalid) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = gnt_idx;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // rvalid is only forwarded in RDWAIT, so one coinciding with ready in XFER is dropped
    always_comb begin
        m_req = gnt_req;
        if (state_q == ST_RDWAIT) begin
            m_req[OFF_VALID] = 1'b0;
        end
        s_resp = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                if (state_q == ST_XFER) begin
                    s_resp[i*RESP_W + RESP_READY_OFF] = m_ready;
                end
                if ((state_q == ST_RDWAIT) && m_rvalid) begin
                    s_resp[i*RESP_W + RESP_RVALID_OFF]            = 1'b1;
                    s_resp[i*RESP_W + RESP_RDATA_OFF +: DATA_W] = m_rdata;
                end
            end
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iob_vexriscv_bus_arb.sv
// Testbench for iob_vexriscv_bus_arb (default round-robin build): scripted
// requester/slave stimulus with a grant and read-data scoreboard.
`timescale 1ns/1ps
module tb_iob_vexriscv_bus_arb;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int REQ_W  = 1 + AW + DW + DW / 8;
    localparam int RESP_W = DW + 2;

    logic                 clk;
    logic                 rst;
    logic [2*REQ_W-1:0]   s_req;
    logic [2*RESP_W-1:0]  s_resp;
    logic [REQ_W-1:0]     m_req;
    logic [RESP_W-1:0]    m_resp;
    logic [1:0]           grant;
    logic                 busy;

    logic [3*REQ_W-1:0]   s_req3;
    logic [3*RESP_W-1:0]  s_resp3;
    logic [REQ_W-1:0]     m_req3;
    logic [RESP_W-1:0]    m_resp3;
    logic [2:0]           grant3;
    logic                 busy3;

    int total;
    int bad;

    logic [1:0]  exp_grant_q[$];
    logic [63:0] exp_rd_q[$];   // {port, rdata}

    iob_vexriscv_bus_arb #(.N_REQ(2), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .s_req(s_req), .s_resp(s_resp),
        .m_req(m_req), .m_resp(m_resp), .grant(grant), .busy(busy)
    );

    iob_vexriscv_bus_arb #(.N_REQ(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
        .clk(clk), .rst(rst), .s_req(s_req3), .s_resp(s_resp3),
        .m_req(m_req3), .m_resp(m_resp3), .grant(grant3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [REQ_W-1:0] mk_req(logic v, logic [31:0] a, logic [31:0] d, logic [3:0] s);
        return {v, a, d, s};
    endfunction

    function automatic logic [RESP_W-1:0] mk_resp(logic [31:0] d, logic rv, logic rdy);
        return {d, rv, rdy};
    endfunction

    task automatic set_req(input int p, input logic [REQ_W-1:0] v);
        s_req[p*REQ_W +: REQ_W] = v;
    endtask

    task automatic set_req3(input int p, input logic [REQ_W-1:0] v);
        s_req3[p*REQ_W +: REQ_W] = v;
    endtask

    // Scoreboard monitor for the 2-port instance
    initial begin : monitor
        logic [1:0]        prev_g;
        logic [1:0]        eg;
        logic [RESP_W-1:0] r;
        logic [63:0]       e;
        prev_g = '0;
        forever begin
            @(negedge clk);
            #2;
            if (grant != 2'b00 && prev_g == 2'b00) begin
                total++;
                if (exp_grant_q.size() == 0) begin
                    bad++;
                    $display("FAIL grant_seq: got %b, none expected", grant);
                end else begin
                    eg = exp_grant_q.pop_front();
                    if (grant !== eg) begin
                        bad++;
                        $display("FAIL grant_seq: got %b want %b", grant, eg);
                    end
                end
            end
            if (grant != 2'b00 && prev_g != 2'b00) begin
                total++;
                if (grant !== prev_g) begin
                    bad++;
                    $display("FAIL grant_no_idle: got %b after %b", grant, prev_g);
                end
            end
            if (grant == 2'b00) begin
                total++;
                if (m_req !== '0) begin
                    bad++;
                    $display("FAIL m_req_idle: got %h want 0", m_req);
                end
            end
            for (int p = 0; p < 2; p++) begin
                r = s_resp[p*RESP_W +: RESP_W];
                if (!grant[p]) begin
                    total++;
                    if (r !== '0) begin
                        bad++;
                        $display("FAIL nongranted_resp port%0d: got %h want 0", p, r);
                    end
                end else if (r[1]) begin
                    total++;
                    if (exp_rd_q.size() == 0) begin
                        bad++;
                        $display("FAIL rvalid port%0d: got rdata %h, none expected", p, r[RESP_W-1:2]);
                    end else begin
                        e = exp_rd_q.pop_front();
                        if ({32'(p), r[RESP_W-1:2]} !== e) begin
                            bad++;
                            $display("FAIL rdata: got port%0d %h want port%0d %h", p, r[RESP_W-1:2], e[63:32], e[31:0]);
                        end
                    end
                end
            end
            prev_g = grant;
        end
    end

    task automatic test_reset();
        rst    = 1'b0;
        s_req  = {mk_req(1'b1, 32'h20, 32'h0, 4'hF), mk_req(1'b1, 32'h10, 32'h0, 4'h0)};
        s_req3 = '0;
        m_resp = mk_resp(32'hFFFF_FFFF, 1'b1, 1'b1);
        m_resp3 = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (s_resp !== '0) begin bad++; $display("FAIL reset_s_resp: got %h want 0", s_resp); end
        total++; if (m_req !== '0)  begin bad++; $display("FAIL reset_m_req: got %h want 0", m_req); end
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", grant); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (grant3 !== 3'b000 || busy3 !== 1'b0) begin bad++; $display("FAIL reset_dut3: got grant %b busy %b want 000 0", grant3, busy3); end
        @(negedge clk);
        s_req  = '0;
        m_resp = '0;
        rst    = 1'b0;
    endtask

    task automatic test_contention();
        exp_grant_q.push_back(2'b01);
        exp_grant_q.push_back(2'b10);
        exp_grant_q.push_back(2'b01);
        exp_grant_q.push_back(2'b10);
        m_resp = mk_resp(32'h0, 1'b0, 1'b1);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            s_req = (c < 8) ? {mk_req(1'b1, 32'h44, 32'h1, 4'h1), mk_req(1'b1, 32'h40, 32'h0, 4'h1)} : '0;
            #1;
            total++;
            if (busy !== (c % 2 == 1)) begin
                bad++;
                $display("FAIL contention_busy c=%0d: got %b want %b", c, busy, (c % 2 == 1));
            end
        end
        m_resp = '0;
    endtask

    task automatic test_single_read();
        exp_grant_q.push_back(2'b10);
        exp_rd_q.push_back({32'd1, 32'hDEAD_BEEF});
        @(negedge clk);
        set_req(1, mk_req(1'b1, 32'h100, 32'h0, 4'h0));
        #1;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rd_arb_cycle: got grant %b want 00", grant); end
        @(negedge clk);
        m_resp = mk_resp(32'h0, 1'b0, 1'b1);
        #1;
        total++; if (m_req !== mk_req(1'b1, 32'h100, 32'h0, 4'h0)) begin bad++; $display("FAIL rd_m_req: got %h want %h", m_req, mk_req(1'b1, 32'h100, 32'h0, 4'h0)); end
        total++; if (s_resp[RESP_W +: RESP_W] !== mk_resp(32'h0, 1'b0, 1'b1)) begin bad++; $display("FAIL rd_ready_p1: got %h", s_resp[RESP_W +: RESP_W]); end
        @(negedge clk);
        set_req(1, '0);
        m_resp = '0;
        #1;
        total++; if (busy !== 1'b1 || m_req[REQ_W-1] !== 1'b0 || grant !== 2'b10) begin bad++; $display("FAIL rd_rdwait: got busy %b valid %b grant %b want 1 0 10", busy, m_req[REQ_W-1], grant); end
        @(negedge clk);
        m_resp = mk_resp(32'hDEAD_BEEF, 1'b1, 1'b0);
        #1;
        total++; if (s_resp[RESP_W +: RESP_W] !== mk_resp(32'hDEAD_BEEF, 1'b1, 1'b0)) begin bad++; $display("FAIL rd_resp_p1: got %h want %h", s_resp[RESP_W +: RESP_W], mk_resp(32'hDEAD_BEEF, 1'b1, 1'b0)); end
        @(negedge clk);
        m_resp = '0;
        #1;
        total++; if (grant !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL rd_done: got grant %b busy %b want 00 0", grant, busy); end
    endtask

    task automatic test_backpressure();
        exp_grant_q.push_back(2'b01);
        exp_grant_q.push_back(2'b10);
        exp_rd_q.push_back({32'd0, 32'hAAAA_0300});
        exp_rd_q.push_back({32'd1, 32'hBBBB_0304});
        @(negedge clk);
        set_req(0, mk_req(1'b1, 32'h300, 32'h0, 4'h0));
        set_req(1, mk_req(1'b1, 32'h304, 32'h0, 4'h0));
        m_resp = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (m_req !== mk_req(1'b1, 32'h300, 32'h0, 4'h0) || busy !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold c=%0d: got m_req %h busy %b", c, m_req, busy);
            end
        end
        @(negedge clk);
        m_resp = mk_resp(32'h0, 1'b0, 1'b1);
        #1;
        total++; if (s_resp[0 +: RESP_W] !== mk_resp(32'h0, 1'b0, 1'b1)) begin bad++; $display("FAIL bp_ready_p0: got %h", s_resp[0 +: RESP_W]); end
        @(negedge clk);
        set_req(0, '0);
        m_resp = '0;
        @(negedge clk);
        m_resp = mk_resp(32'hAAAA_0300, 1'b1, 1'b0);
        @(negedge clk);
        m_resp = '0;
        @(negedge clk);
        m_resp = mk_resp(32'h0, 1'b0, 1'b1);
        #1;
        total++; if (m_req !== mk_req(1'b1, 32'h304, 32'h0, 4'h0) || grant !== 2'b10) begin bad++; $display("FAIL bp_pending_p1: got m_req %h grant %b", m_req, grant); end
        @(negedge clk);
        set_req(1, '0);
        m_resp = '0;
        @(negedge clk);
        m_resp = mk_resp(32'hBBBB_0304, 1'b1, 1'b0);
        @(negedge clk);
        m_resp = '0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_done: got busy %b want 0", busy); end
    endtask

    task automatic test_write();
        exp_grant_q.push_back(2'b01);
        @(negedge clk);
        set_req(0, mk_req(1'b1, 32'h200, 32'h1234_5678, 4'hF));
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_arb_cycle: got busy %b want 0", busy); end
        @(negedge clk);
        m_resp = mk_resp(32'h0, 1'b0, 1'b1);
        #1;
        total++; if (m_req !== mk_req(1'b1, 32'h200, 32'h1234_5678, 4'hF)) begin bad++; $display("FAIL wr_m_req: got %h want %h", m_req, mk_req(1'b1, 32'h200, 32'h1234_5678, 4'hF)); end
        total++; if (s_resp[0 +: RESP_W] !== mk_resp(32'h0, 1'b0, 1'b1)) begin bad++; $display("FAIL wr_ready_p0: got %h", s_resp[0 +: RESP_W]); end
        @(negedge clk);
        set_req(0, '0);
        m_resp = '0;
        #1;
        total++; if (busy !== 1'b0 || grant !== 2'b00) begin bad++; $display("FAIL wr_idle: got busy %b grant %b want 0 00", busy, grant); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_rdwait();
        exp_grant_q.push_back(2'b10);
        @(negedge clk);
        set_req(1, mk_req(1'b1, 32'h400, 32'h0, 4'h0));
        @(negedge clk);
        m_resp = mk_resp(32'h0, 1'b0, 1'b1);
        @(negedge clk);
        set_req(1, '0);
        m_resp = '0;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_rdwait_busy: got %b want 1", busy); end
        #3 rst = 1'b1;
        #1;
        total++; if (s_resp !== '0 || m_req !== '0 || grant !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL rst_rdwait_outputs: got s_resp %h m_req %h grant %b busy %b", s_resp, m_req, grant, busy); end
        @(negedge clk);
        m_resp = mk_resp(32'hBAD0_BAD0, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        total++; if (s_resp !== '0 || busy !== 1'b0) begin bad++; $display("FAIL rst_late_rvalid: got s_resp %h busy %b want 0 0", s_resp, busy); end
        @(negedge clk);
        m_resp = '0;
    endtask

    task automatic test_wrap3();
        @(negedge clk);
        set_req3(2, mk_req(1'b1, 32'h500, 32'h5, 4'h1));
        @(negedge clk);
        m_resp3 = mk_resp(32'h0, 1'b0, 1'b1);
        #1;
        total++; if (grant3 !== 3'b100) begin bad++; $display("FAIL wrap_first: got %b want 100", grant3); end
        @(negedge clk);
        s_req3  = '0;
        m_resp3 = '0;
        #1;
        total++; if (grant3 !== 3'b000) begin bad++; $display("FAIL wrap_idle1: got %b want 000", grant3); end
        @(negedge clk);
        set_req3(0, mk_req(1'b1, 32'h600, 32'h6, 4'h1));
        set_req3(2, mk_req(1'b1, 32'h604, 32'h7, 4'h1));
        @(negedge clk);
        m_resp3 = mk_resp(32'h0, 1'b0, 1'b1);
        #1;
        total++; if (grant3 !== 3'b001) begin bad++; $display("FAIL wrap_to_port0: got %b want 001", grant3); end
        @(negedge clk);
        set_req3(0, '0);
        m_resp3 = '0;
        #1;
        total++; if (grant3 !== 3'b000) begin bad++; $display("FAIL wrap_idle2: got %b want 000", grant3); end
        @(negedge clk);
        m_resp3 = mk_resp(32'h0, 1'b0, 1'b1);
        #1;
        total++; if (grant3 !== 3'b100) begin bad++; $display("FAIL wrap_then_port2: got %b want 100", grant3); end
        @(negedge clk);
        s_req3  = '0;
        m_resp3 = '0;
        #1;
        total++; if (grant3 !== 3'b000 || busy3 !== 1'b0) begin bad++; $display("FAIL wrap_done: got grant %b busy %b want 000 0", grant3, busy3); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_contention();
        test_single_read();
        test_backpressure();
        test_write();
        test_reset_rdwait();
        test_wrap3();
        repeat (2) @(negedge clk);
        #3;
        total++; if (exp_grant_q.size() != 0) begin bad++; $display("FAIL grant_queue_left: got %0d want 0", exp_grant_q.size()); end
        total++; if (exp_rd_q.size() != 0) begin bad++; $display("FAIL rdata_queue_left: got %0d want 0", exp_rd_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
